// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 8-bit LFSR byte stream (taps 8,6,5,4).
// Define LFSR_CHK_BER_EN to enable the per-bit error counter.
module lfsr_stream_checker #(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        clr_err,
   output logic [1:0]  state,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_cnt,
   output logic [15:0] bit_err_cnt
);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCK   = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
   localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

   state_t      r_state;
   logic [7:0]  r_pred;
   logic [7:0]  r_run;
   logic [3:0]  r_miss;
   logic        r_locked;
   logic        r_err_pulse;
   logic [15:0] r_err_cnt;

   logic        w_match;
   logic        w_zero;
   logic        w_err;
   logic [7:0]  w_step_in;
   logic [7:0]  w_step_pred;
   logic [7:0]  w_run_inc;
   logic [3:0]  w_miss_inc;
   logic [15:0] w_err_base;
   logic [15:0] w_err_nxt;

   function automatic logic [7:0] f_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   assign w_match     = (in_data == r_pred);
   assign w_zero      = (in_data == 8'h00);
   assign w_step_in   = f_step(in_data);
   assign w_step_pred = f_step(r_pred);
   assign w_run_inc   = r_run + 8'd1;
   assign w_miss_inc  = r_miss + 4'd1;
   assign w_err       = in_valid && (r_state == S_LOCK) && !w_match;

   // clear first, then count the error of the same cycle
   assign w_err_base = clr_err ? 16'h0000 : r_err_cnt;
   assign w_err_nxt  = (w_err && (w_err_base != 16'hFFFF)) ?
                       w_err_base + 16'd1 : w_err_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_HUNT;
         r_pred      <= 8'h00;
         r_run       <= 8'h00;
         r_miss      <= 4'h0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= 16'h0000;
      end else begin
         r_err_pulse <= w_err;
         r_err_cnt   <= w_err_nxt;
         if (in_valid) begin
            unique case (r_state)
               S_HUNT: begin
                  if (!w_zero) begin
                     r_pred  <= w_step_in;
                     r_run   <= 8'h00;
                     r_state <= S_VERIFY;
                  end
               end
               S_VERIFY: begin
                  if (w_match) begin
                     r_pred <= w_step_in;
                     r_run  <= w_run_inc;
                     if (w_run_inc == LOCK_TGT) begin
                        r_state  <= S_LOCK;
                        r_locked <= 1'b1;
                        r_miss   <= 4'h0;
                     end
                  end else if (!w_zero) begin
                     r_pred <= w_step_in;
                     r_run  <= 8'h00;
                  end else begin
                     r_state <= S_HUNT;
                  end
               end
               S_LOCK: begin
                  // flywheel: never reseed from received data while locked
                  r_pred <= w_step_pred;
                  if (w_match) begin
                     r_miss <= 4'h0;
                  end else begin
                     r_miss <= w_miss_inc;
                     if (w_miss_inc == LOSS_TGT) begin
                        r_state  <= S_HUNT;
                        r_locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state  <= S_HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef LFSR_CHK_BER_EN
   logic [15:0] r_bit_err_cnt;
   logic [7:0]  w_diff;
   logic [3:0]  w_pop;
   logic [15:0] w_bit_base;
   logic [16:0] w_bit_sum;

   assign w_diff = in_data ^ r_pred;

   always_comb begin
      w_pop = 4'h0;
      for (int i = 0; i < 8; i++) begin
         w_pop = w_pop + {3'b000, w_diff[i]};
      end
   end

   assign w_bit_base = clr_err ? 16'h0000 : r_bit_err_cnt;
   assign w_bit_sum  = {1'b0, w_bit_base} + {13'h0000, w_pop};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_err_cnt <= 16'h0000;
      end else if (w_err) begin
         r_bit_err_cnt <= w_bit_sum[16] ? 16'hFFFF : w_bit_sum[15:0];
      end else begin
         r_bit_err_cnt <= w_bit_base;
      end
   end

   assign bit_err_cnt = r_bit_err_cnt;
`else
   assign bit_err_cnt = 16'h0000;
`endif

   assign state     = r_state;
   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: directed and random byte streams
// compared against a behavioural receiver model.
module tb_lfsr_stream_checker;

   localparam int LOCK_CNT = 16;
   localparam int LOSS_CNT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        clr_err;
   logic [1:0]  state;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [15:0] bit_err_cnt;

   int checks = 0;
   int errors = 0;

   lfsr_stream_checker #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .clr_err     (clr_err),
      .state       (state),
      .locked      (locked),
      .err_pulse   (err_pulse),
      .err_cnt     (err_cnt),
      .bit_err_cnt (bit_err_cnt)
   );

   always #5 clk = ~clk;

   // receiver model: 0 hunting, 1 verifying, 2 locked
   int         m_state;
   int         m_run;
   int         m_miss;
   int         m_err;
   int         m_bit;
   int         m_pulse;
   logic [7:0] m_pred;
   logic [7:0] gen;

   // next LFSR value: shift left, feedback = parity of bits 7,5,4,3
   function automatic logic [7:0] nxt(input logic [7:0] s);
      int v;
      v = (int'(s) * 2) % 256 + ($countones(s & 8'hB8) % 2);
      return 8'(v);
   endfunction

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, 16'(state), 16'(m_state));
      chk({tag, ".locked"}, 16'(locked), 16'(m_state == 2));
      chk({tag, ".err_pulse"}, 16'(err_pulse), 16'(m_pulse));
      chk({tag, ".err_cnt"}, err_cnt, 16'(m_err));
      chk({tag, ".bit_err_cnt"}, bit_err_cnt, 16'(m_bit));
   endtask

   task automatic model_reset();
      m_state = 0;
      m_run   = 0;
      m_miss  = 0;
      m_err   = 0;
      m_bit   = 0;
      m_pulse = 0;
      m_pred  = 8'h00;
   endtask

   task automatic do_reset(input string tag);
      rst      = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      clr_err  = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_reset();
      #1;
      check_all(tag);
      rst = 1'b0;
   endtask

   task automatic apply(input bit v, input logic [7:0] d, input bit c,
                        input string tag);
      bit bad;
      int nb;
      bad = 0;
      nb  = 0;
      in_valid = v;
      in_data  = d;
      clr_err  = c;
      if (v) begin
         if (m_state == 0) begin
            if (d != 8'h00) begin
               m_pred  = nxt(d);
               m_run   = 0;
               m_state = 1;
            end
         end else if (m_state == 1) begin
            if (d == m_pred) begin
               m_pred = nxt(d);
               m_run  = m_run + 1;
               if (m_run == LOCK_CNT) begin
                  m_state = 2;
                  m_miss  = 0;
               end
            end else if (d != 8'h00) begin
               m_pred = nxt(d);
               m_run  = 0;
            end else begin
               m_state = 0;
            end
         end else begin
            if (d != m_pred) begin
               bad    = 1;
               nb     = $countones(d ^ m_pred);
               m_miss = m_miss + 1;
               if (m_miss == LOSS_CNT) m_state = 0;
            end else begin
               m_miss = 0;
            end
            m_pred = nxt(m_pred);
         end
      end
      if (c) begin
         m_err = 0;
         m_bit = 0;
      end
      m_pulse = bad;
      if (bad) begin
         m_err = sat(m_err + 1);
`ifdef LFSR_CHK_BER_EN
         m_bit = sat(m_bit + nb);
`endif
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send_good(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) apply(0, 8'($urandom), 0, tag);
         apply(1, gen, 0, tag);
         gen = nxt(gen);
      end
   endtask

   task automatic send_bad(input string tag, input bit c);
      logic [7:0] m;
      m = 8'($urandom_range(1, 255));
      apply(1, gen ^ m, c, tag);
      gen = nxt(gen);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clr_err  = 1'b0;
      model_reset();
      @(posedge clk);
      do_reset("reset");
      chk("reset.state_hunt", 16'(state), 16'd0);

      // lock from a continuous stream seeded at 0x01
      gen = 8'h01;
      apply(1, gen, 0, "seed");
      gen = nxt(gen);
      chk("seed.verify", 16'(state), 16'd1);
      send_good(15, "lockup");
      chk("lockup.not_yet", 16'(locked), 16'd0);
      send_good(1, "lockup");
      chk("lockup.locked", 16'(locked), 16'd1);
      chk("lockup.no_err", err_cnt, 16'd0);

      // single corrupted byte, one bit flipped
      apply(1, gen ^ 8'h01, 0, "corrupt");
      gen = nxt(gen);
      chk("corrupt.pulse", 16'(err_pulse), 16'd1);
      chk("corrupt.cnt", err_cnt, 16'd1);
      send_good(1, "after_corrupt");
      chk("after_corrupt.pulse_gone", 16'(err_pulse), 16'd0);
      chk("after_corrupt.locked", 16'(locked), 16'd1);

      // LOSS_CNT consecutive bad bytes drop lock, then relock
      for (int i = 0; i < LOSS_CNT; i++) send_bad("loss", 0);
      chk("loss.hunt", 16'(state), 16'd0);
      chk("loss.cnt", err_cnt, 16'(1 + LOSS_CNT));
      send_good(LOCK_CNT, "relock");
      chk("relock.not_yet", 16'(locked), 16'd0);
      send_good(1, "relock");
      chk("relock.locked", 16'(locked), 16'd1);

      // zeros are ignored while hunting
      do_reset("reset2");
      for (int i = 0; i < 3; i++) apply(1, 8'h00, 0, "zeros");
      chk("zeros.hunt", 16'(state), 16'd0);
      gen = 8'h01;
      send_good(1, "after_zeros");
      chk("after_zeros.verify", 16'(state), 16'd1);

      // mismatch in VERIFY reseeds from the bad byte
      send_good(10, "verify10");
      apply(1, 8'h55, 0, "reseed");
      chk("reseed.no_pulse", 16'(err_pulse), 16'd0);
      gen = nxt(8'h55);
      send_good(LOCK_CNT - 1, "reseed_run");
      chk("reseed_run.verify", 16'(state), 16'd1);
      send_good(1, "reseed_run");
      chk("reseed_run.locked", 16'(locked), 16'd1);

      // random mixture of good, bad, zero and idle cycles
      for (int i = 0; i < 400; i++) begin
         int r;
         bit c;
         r = $urandom_range(0, 99);
         c = ($urandom_range(0, 24) == 0);
         if (r < 10) apply(0, 8'($urandom), c, "rand_idle");
         else if (r < 14) apply(1, 8'h00, c, "rand_zero");
         else if (r < 24) send_bad("rand_bad", c);
         else begin
            apply(1, gen, c, "rand_good");
            gen = nxt(gen);
         end
      end

      // make sure we are locked again
      do_reset("reset3");
      gen = 8'h5A;
      send_good(LOCK_CNT + 1, "lock3");
      chk("lock3.locked", 16'(locked), 16'd1);

      // preload err_cnt close to saturation
      force dut.r_err_cnt = 16'hFFFD;
      #1;
      release dut.r_err_cnt;
      m_err = 65533;
      send_bad("sat", 0);
      send_good(1, "sat");
      send_bad("sat", 0);
      chk("sat.full", err_cnt, 16'hFFFF);
      send_good(1, "sat");
      send_bad("sat", 0);
      chk("sat.hold", err_cnt, 16'hFFFF);
      send_good(1, "sat");

      // clear on the same cycle as an error
      send_bad("clr_err", 1);
      chk("clr_err.one", err_cnt, 16'd1);
      chk("clr_err.pulse", 16'(err_pulse), 16'd1);
      send_good(2, "clr_err");

      // reset while locked
      do_reset("reset_locked");
      chk("reset_locked.locked", 16'(locked), 16'd0);
      chk("reset_locked.err", err_cnt, 16'd0);
      gen = 8'h33;
      send_good(1, "reset_reseed");
      chk("reset_reseed.verify", 16'(state), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
